// File: rtl/hash_table_pkg.sv
// Shared hash table types: operation encoding and the modify classification
// used by the issue stage's same-key hazard check.
package hash_table_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_READ   = 2'b01,
    OP_WRITE  = 2'b10,
    OP_DELETE = 2'b11
  } op_t;

  function automatic logic is_modify(op_t op);
    return (op == OP_WRITE) || (op == OP_DELETE);
  endfunction

endpackage

// File: rtl/request_fifo.sv
// Synchronous request buffer with asynchronous reset. The head word is always
// presented on pop_data; push while full and pop while empty are ignored.
module request_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/hash_op_scheduler.sv
// Issue stage in front of the hash table: buffers host requests and holds back
// same-key requests while an earlier modify is in flight. HASH_SCHED_STATS_EN adds counters.
module hash_op_scheduler
  import hash_table_pkg::*;
#(
  parameter int KEY_WIDTH     = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int HAZARD_WINDOW = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [KEY_WIDTH-1:0]          key_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic [1:0]                    op_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [KEY_WIDTH-1:0]          key_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [1:0]                    op_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          stall_o
`ifdef HASH_SCHED_STATS_EN
  ,
  output logic [31:0]                   issued_cnt_o,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam int FW = 2 + KEY_WIDTH + DATA_WIDTH;

  typedef struct packed {
    logic                 vld;
    logic [KEY_WIDTH-1:0] key;
    logic                 mod;
  } win_entry_t;

  logic [FW-1:0]         head_word;
  logic [1:0]            head_op;
  logic [KEY_WIDTH-1:0]  head_key;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_mod;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  issue;
  logic                  hazard;
  logic                  rst_done;
  logic [KEY_WIDTH-1:0]  last_key;
  logic [DATA_WIDTH-1:0] last_data;
  win_entry_t            win [HAZARD_WINDOW];

  assign push    = valid_i && ready_o && (op_i != OP_NOP);
  assign issue   = valid_o && ready_i;
  assign ready_o = rst_done && !full;

  request_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({op_i, key_i, data_i}),
    .pop       (issue),
    .pop_data  (head_word),
    .full      (full),
    .empty     (empty),
    .count     (count_o)
  );

  assign head_op   = head_word[FW-1 -: 2];
  assign head_key  = head_word[KEY_WIDTH+DATA_WIDTH-1 -: KEY_WIDTH];
  assign head_data = head_word[DATA_WIDTH-1:0];
  assign head_mod  = is_modify(op_t'(head_op));

  // Read-after-read is the only same-key pairing allowed through.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_WINDOW; i++) begin
      if (win[i].vld && (win[i].key == head_key) && (win[i].mod || head_mod))
        hazard = 1'b1;
    end
  end

  assign valid_o = !empty && !hazard;
  assign stall_o = !empty && hazard;
  assign key_o   = empty ? last_key  : head_key;
  assign data_o  = empty ? last_data : head_data;
  assign op_o    = empty ? OP_NOP    : head_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_done  <= 1'b0;
      last_key  <= '0;
      last_data <= '0;
    end else begin
      rst_done <= 1'b1;
      if (!empty) begin
        last_key  <= head_key;
        last_data <= head_data;
      end
    end
  end

  // The window tracks pipeline occupancy, so it only advances with ready_i.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HAZARD_WINDOW; i++)
        win[i] <= '0;
    end else if (ready_i) begin
      win[0] <= issue ? '{vld: 1'b1, key: key_o, mod: head_mod} : '0;
      for (int i = 1; i < HAZARD_WINDOW; i++)
        win[i] <= win[i-1];
    end
  end

`ifdef HASH_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt_o <= '0;
      stall_cnt_o  <= '0;
    end else begin
      if (issue)
        issued_cnt_o <= issued_cnt_o + 32'd1;
      if (stall_o && ready_i)
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_op_scheduler.sv
// Directed bench for hash_op_scheduler; define HASH_SCHED_STATS_EN to also cover the counters.
module tb_hash_op_scheduler;

  logic        clk;
  logic        reset;
  logic [1:0]  key_i;
  logic [31:0] data_i;
  logic [1:0]  op_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  key_o;
  logic [31:0] data_o;
  logic [1:0]  op_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  count_o;
  logic        stall_o;
`ifdef HASH_SCHED_STATS_EN
  logic [31:0] issued_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  hash_op_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .key_i   (key_i),
    .data_i  (data_i),
    .op_i    (op_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .key_o   (key_o),
    .data_o  (data_o),
    .op_o    (op_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .count_o (count_o),
    .stall_o (stall_o)
`ifdef HASH_SCHED_STATS_EN
    ,
    .issued_cnt_o (issued_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] k, input logic [31:0] d);
    valid_i = v;
    op_i    = op;
    key_i   = k;
    data_i  = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'b00, 2'd0, 32'd0);
    ready_i = 1'b1;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 2'b00, 2'd0, 32'd0);
    ready_i = 1'b0;
    repeat (3) tick();
    vec_cnt++;
    if (ready_o !== 1'b0 || valid_o !== 1'b0 || op_o !== 2'b00 || count_o !== 3'd0 ||
        stall_o !== 1'b0 || key_o !== 2'd0 || data_o !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_state: ready=%b valid=%b op=%b count=%0d stall=%b key=%0d data=%h, required 0 0 00 0 0 0 0",
               ready_o, valid_o, op_o, count_o, stall_o, key_o, data_o);
    end
    reset = 1'b0;
    tick();
    vec_cnt++;
    if (ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_release_ready: got %b required 1", ready_o);
    end
  endtask

  task automatic test_nop_discard();
    ready_i = 1'b1;
    drive(1'b1, 2'b00, 2'd1, 32'hDEAD);
    tick();
    vec_cnt++;
    if (count_o !== 3'd0 || valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL nop_discard: count=%0d valid=%b required 0 0", count_o, valid_o);
    end
    drive(1'b1, 2'b01, 2'd1, 32'd0);
    tick();
    drive(1'b0, 2'b00, 2'd0, 32'd0);
    vec_cnt++;
    if (count_o !== 3'd1 || valid_o !== 1'b1 || op_o !== 2'b01 || key_o !== 2'd1) begin
      err_cnt++;
      $display("FAIL nop_read_issue: count=%0d valid=%b op=%b key=%0d required 1 1 01 1",
               count_o, valid_o, op_o, key_o);
    end
    tick();
    vec_cnt++;
    if (count_o !== 3'd0 || valid_o !== 1'b0 || op_o !== 2'b00 || key_o !== 2'd1) begin
      err_cnt++;
      $display("FAIL nop_after_issue: count=%0d valid=%b op=%b key=%0d required 0 0 00 1",
               count_o, valid_o, op_o, key_o);
    end
    idle(3);
  endtask

  // Write then dependent read on key 2; stall_cyc selects a ready_i=0 cycle at T+1.
  task automatic test_hazard(input bit stall_cyc, input logic [31:0] wdata);
    int issue_at;
    ready_i = 1'b1;
    drive(1'b1, 2'b10, 2'd2, wdata);
    tick();
    drive(1'b1, 2'b01, 2'd2, 32'd0);
    vec_cnt++;
    if (valid_o !== 1'b1 || op_o !== 2'b10 || key_o !== 2'd2 || data_o !== wdata) begin
      err_cnt++;
      $display("FAIL hazard_write_head(%0d): valid=%b op=%b key=%0d data=%h required 1 10 2 %h",
               stall_cyc, valid_o, op_o, key_o, data_o, wdata);
    end
    tick();  // now in T+1
    drive(1'b0, 2'b00, 2'd0, 32'd0);
    if (stall_cyc) ready_i = 1'b0;
    issue_at = stall_cyc ? 4 : 3;
    for (int t = 1; t < issue_at; t++) begin
      vec_cnt++;
      if (stall_o !== 1'b1 || valid_o !== 1'b0 || op_o !== 2'b01 || count_o !== 3'd1) begin
        err_cnt++;
        $display("FAIL hazard_block(%0d) T+%0d: stall=%b valid=%b op=%b count=%0d required 1 0 01 1",
                 stall_cyc, t, stall_o, valid_o, op_o, count_o);
      end
      tick();
      ready_i = 1'b1;
    end
    vec_cnt++;
    if (stall_o !== 1'b0 || valid_o !== 1'b1 || op_o !== 2'b01 || key_o !== 2'd2) begin
      err_cnt++;
      $display("FAIL hazard_release(%0d) T+%0d: stall=%b valid=%b op=%b key=%0d required 0 1 01 2",
               stall_cyc, issue_at, stall_o, valid_o, op_o, key_o);
    end
    tick();
    vec_cnt++;
    if (count_o !== 3'd0 || valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL hazard_drained(%0d): count=%0d valid=%b required 0 0", stall_cyc, count_o, valid_o);
    end
    idle(3);
  endtask

  task automatic test_full_fifo();
    logic [1:0]  exp_key [4];
    logic [31:0] exp_data[4];
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 2'(i), 32'h10 + 32'(i));
      tick();
      vec_cnt++;
      if (count_o !== 3'(i + 1) || ready_o !== (i < 3)) begin
        err_cnt++;
        $display("FAIL full_fill[%0d]: count=%0d ready=%b required %0d %b", i, count_o, ready_o, i + 1, (i < 3));
      end
    end
    drive(1'b1, 2'b10, 2'd0, 32'h14);
    tick();
    vec_cnt++;
    if (count_o !== 3'd4 || ready_o !== 1'b0 || valid_o !== 1'b1 || key_o !== 2'd0) begin
      err_cnt++;
      $display("FAIL full_hold: count=%0d ready=%b valid=%b key=%0d required 4 0 1 0",
               count_o, ready_o, valid_o, key_o);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    vec_cnt++;
    if (count_o !== 3'd3 || ready_o !== 1'b1 || key_o !== 2'd1) begin
      err_cnt++;
      $display("FAIL full_pop_no_push: count=%0d ready=%b key=%0d required 3 1 1", count_o, ready_o, key_o);
    end
    tick();
    drive(1'b0, 2'b00, 2'd0, 32'd0);
    vec_cnt++;
    if (count_o !== 3'd4 || ready_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_fifth_accept: count=%0d ready=%b required 4 0", count_o, ready_o);
    end
    exp_key  = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_data = '{32'h11, 32'h12, 32'h13, 32'h14};
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (valid_o !== 1'b1 || key_o !== exp_key[i] || data_o !== exp_data[i] || op_o !== 2'b10) begin
        err_cnt++;
        $display("FAIL full_drain[%0d]: valid=%b key=%0d data=%h op=%b required 1 %0d %h 10",
                 i, valid_o, key_o, data_o, op_o, exp_key[i], exp_data[i]);
      end
      tick();
    end
    vec_cnt++;
    if (count_o !== 3'd0) begin
      err_cnt++;
      $display("FAIL full_empty: count=%0d required 0", count_o);
    end
    idle(3);
  endtask

  task automatic test_mid_reset();
    ready_i = 1'b0;
    drive(1'b1, 2'b10, 2'd1, 32'h77);
    repeat (2) tick();
    drive(1'b0, 2'b00, 2'd0, 32'd0);
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (count_o !== 3'd0 || valid_o !== 1'b0 || ready_o !== 1'b0 || key_o !== 2'd0 || data_o !== 32'd0) begin
      err_cnt++;
      $display("FAIL mid_reset_async: count=%0d valid=%b ready=%b key=%0d data=%h required 0 0 0 0 0",
               count_o, valid_o, ready_o, key_o, data_o);
    end
    ready_i = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    vec_cnt++;
    if (count_o !== 3'd0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      err_cnt++;
      $display("FAIL mid_reset_after: count=%0d valid=%b ready=%b required 0 0 1", count_o, valid_o, ready_o);
    end
  endtask

  task automatic test_back_to_back_reads();
    ready_i = 1'b1;
    drive(1'b1, 2'b01, 2'd3, 32'd0);
    tick();
    vec_cnt++;
    if (valid_o !== 1'b1 || key_o !== 2'd3 || op_o !== 2'b01) begin
      err_cnt++;
      $display("FAIL rar_first: valid=%b key=%0d op=%b required 1 3 01", valid_o, key_o, op_o);
    end
    tick();
    drive(1'b0, 2'b00, 2'd0, 32'd0);
    vec_cnt++;
    if (valid_o !== 1'b1 || stall_o !== 1'b0 || key_o !== 2'd3 || count_o !== 3'd1) begin
      err_cnt++;
      $display("FAIL rar_second: valid=%b stall=%b key=%0d count=%0d required 1 0 3 1",
               valid_o, stall_o, key_o, count_o);
    end
    tick();
    vec_cnt++;
    if (count_o !== 3'd0 || valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL rar_drained: count=%0d valid=%b required 0 0", count_o, valid_o);
    end
`ifdef HASH_SCHED_STATS_EN
    vec_cnt++;
    if (issued_cnt_o !== 32'd2 || stall_cnt_o !== 32'd0) begin
      err_cnt++;
      $display("FAIL stats: issued=%0d stalls=%0d required 2 0", issued_cnt_o, stall_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_nop_discard();
    test_hazard(1'b0, 32'hA5);
    test_hazard(1'b1, 32'h5A);
    test_full_fifo();
    test_mid_reset();
    test_back_to_back_reads();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
